// File: rtl/backtrack_ctrl.sv
// backtrack_ctrl
//   Consumer end of the decision stack. On a conflict it pops decision
//   variables, requests unwinding of their implications, then either flips
//   the decision (writes the opposite value and pushes it back) or unassigns
//   it and keeps popping. Pulses resume to the decider after a flip, or goes
//   to a sticky UNSAT state once the stack runs dry. Keeps a per-variable
//   "already flipped" bitmap.
//
// Ports
//   clock, reset              clock; synchronous active-high reset
//   conflict                  conflict pulse from control (ignored while busy)
//   stk_empty, stk_idx_in     decision stack status / popped index
//   stk_pop, stk_push         one-cycle stack requests
//   stk_idx_out               index pushed back after a flip
//   dec_new, dec_new_var      fresh decision: clears that variable's flipped bit
//   unwind_req, unwind_var    unwind request, held until unwind_done
//   unwind_done               unwinder finished
//   asg_rd_en, asg_idx        assignment read strobe / read-write index
//   asg_rd_val                read data (00 unassigned, 01 false, 10 true)
//   asg_wr_en, asg_wr_val     assignment write strobe / value
//   busy                      FSM active (not IDLE, not UNSAT)
//   resume, resume_var        one-cycle restart pulse with the flipped variable
//   unsat                     sticky: search space exhausted
//   err                       sticky: popped variable read back unassigned
module backtrack_ctrl #(
    parameter int MAX_VARS      = 16,
    parameter int MAX_VARS_BITS = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     conflict,
    input  logic                     stk_empty,
    input  logic [MAX_VARS_BITS-1:0] stk_idx_in,
    output logic                     stk_pop,
    output logic                     stk_push,
    output logic [MAX_VARS_BITS-1:0] stk_idx_out,
    input  logic                     dec_new,
    input  logic [MAX_VARS_BITS-1:0] dec_new_var,
    output logic                     unwind_req,
    output logic [MAX_VARS_BITS-1:0] unwind_var,
    input  logic                     unwind_done,
    output logic                     asg_rd_en,
    output logic [MAX_VARS_BITS-1:0] asg_idx,
    input  logic [1:0]               asg_rd_val,
    output logic                     asg_wr_en,
    output logic [1:0]               asg_wr_val,
    output logic                     busy,
    output logic                     resume,
    output logic [MAX_VARS_BITS-1:0] resume_var,
    output logic                     unsat,
    output logic                     err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_POP    = 3'd1;
    localparam logic [2:0] S_UNWIND = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_PUSH   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_UNSAT  = 3'd7;

    logic [2:0]               state;
    logic [2:0]               state_nxt;
    logic [MAX_VARS_BITS-1:0] cur_var;
    logic [MAX_VARS-1:0]      flipped;
    logic                     do_flip;

    // An unassigned read-back takes the same path as an already-flipped one.
    assign do_flip = !flipped[cur_var] && (asg_rd_val != 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (conflict) state_nxt = stk_empty ? S_UNSAT : S_POP;
            S_POP:    state_nxt = S_UNWIND;
            S_UNWIND: if (unwind_done) state_nxt = S_READ;
            S_READ:   state_nxt = S_CHECK;
            S_CHECK: begin
                if (do_flip)        state_nxt = S_PUSH;
                else if (stk_empty) state_nxt = S_UNSAT;
                else                state_nxt = S_POP;
            end
            S_PUSH:   state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            S_UNSAT:  state_nxt = S_UNSAT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            cur_var <= '0;
            flipped <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_POP)
                cur_var <= stk_idx_in;
            if (state == S_CHECK && asg_rd_val == 2'b00)
                err <= 1'b1;
            // Later non-blocking write wins: a CHECK update on the same index
            // overrides a same-cycle clear from a fresh decision.
            if (dec_new)
                flipped[dec_new_var] <= 1'b0;
            if (state == S_CHECK)
                flipped[cur_var] <= do_flip;
        end
    end

    // Moore-style outputs decoded from state; indices gated to zero when idle.
    always_comb begin
        stk_pop     = (state == S_POP);
        stk_push    = (state == S_PUSH);
        stk_idx_out = (state == S_PUSH) ? cur_var : '0;
        unwind_req  = (state == S_UNWIND);
        unwind_var  = (state == S_UNWIND) ? cur_var : '0;
        asg_rd_en   = (state == S_READ);
        asg_wr_en   = (state == S_CHECK);
        asg_idx     = (state == S_READ || state == S_CHECK) ? cur_var : '0;
        asg_wr_val  = '0;
        if (state == S_CHECK && do_flip)
            asg_wr_val = {asg_rd_val[0], asg_rd_val[1]};
        busy        = (state != S_IDLE) && (state != S_UNSAT);
        resume      = (state == S_DONE);
        resume_var  = (state == S_DONE) ? cur_var : '0;
        unsat       = (state == S_UNSAT);
    end

endmodule

// File: tb/tb_backtrack_ctrl.sv
// tb_backtrack_ctrl
//   Bench for backtrack_ctrl. The negedge process models the decision stack
//   and assignment table the DUT talks to, turns DUT activity into events and
//   checks them against a queue filled by the reference model at stimulus time.
module tb_backtrack_ctrl;

    localparam int NV = 16;
    localparam int VB = 4;

    localparam int EV_ERR   = 0;
    localparam int EV_UNSAT = 1;
    localparam int EV_POP   = 2;
    localparam int EV_UW    = 3;
    localparam int EV_RD    = 4;
    localparam int EV_WR    = 5;
    localparam int EV_PUSH  = 6;
    localparam int EV_RES   = 7;

    logic          clock;
    logic          reset = 1'b1;
    logic          conflict = 1'b0;
    logic          stk_empty;
    logic [VB-1:0] stk_idx_in;
    logic          stk_pop, stk_push;
    logic [VB-1:0] stk_idx_out;
    logic          dec_new = 1'b0;
    logic [VB-1:0] dec_new_var = '0;
    logic          unwind_req;
    logic [VB-1:0] unwind_var;
    logic          unwind_done;
    logic          asg_rd_en;
    logic [VB-1:0] asg_idx;
    logic [1:0]    asg_rd_val;
    logic          asg_wr_en;
    logic [1:0]    asg_wr_val;
    logic          busy, resume, unsat, err;
    logic [VB-1:0] resume_var;

    backtrack_ctrl #(.MAX_VARS(NV), .MAX_VARS_BITS(VB)) dut (
        .clock(clock), .reset(reset), .conflict(conflict),
        .stk_empty(stk_empty), .stk_idx_in(stk_idx_in),
        .stk_pop(stk_pop), .stk_push(stk_push), .stk_idx_out(stk_idx_out),
        .dec_new(dec_new), .dec_new_var(dec_new_var),
        .unwind_req(unwind_req), .unwind_var(unwind_var), .unwind_done(unwind_done),
        .asg_rd_en(asg_rd_en), .asg_idx(asg_idx), .asg_rd_val(asg_rd_val),
        .asg_wr_en(asg_wr_en), .asg_wr_val(asg_wr_val),
        .busy(busy), .resume(resume), .resume_var(resume_var),
        .unsat(unsat), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int kind; int v; int n; } ev_t;
    ev_t expq[$];

    int errors = 0;
    int checks = 0;

    // environment (owned by the monitor process)
    int         env_stk[$];
    logic [1:0] env_tab [NV];
    logic [1:0] dec_val = 2'b00;
    bit         dec_push = 1'b0;
    bit         pop_pending = 1'b0;
    int         uw_cnt = 0, uw_var = 0, uw_dly = 0;
    bit         prev_unsat = 1'b0, prev_err = 1'b0, rd_prev = 1'b0;
    int         rd_count = 0, last_res_cyc = -1, last_unsat_cyc = -1, overlaps = 0;

    // reference model (owned by the stimulus process)
    int         ref_stk[$];
    logic [1:0] ref_tab [NV];
    bit         ref_flip[NV];
    bit         ref_unsat = 1'b0, ref_err = 1'b0;
    int         conf_cyc = 0;

    function automatic string kname(int k);
        case (k)
            EV_ERR:   return "err";
            EV_UNSAT: return "unsat";
            EV_POP:   return "pop";
            EV_UW:    return "unwind";
            EV_RD:    return "read";
            EV_WR:    return "write";
            EV_PUSH:  return "push";
            default:  return "resume";
        endcase
    endfunction

    function automatic void check_ev(int k, int v, int n);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL event: got %s v=%0d n=%0d, required no event", kname(k), v, n);
        end else begin
            e = expq.pop_front();
            if (e.kind != k || e.v != v || e.n != n) begin
                errors++;
                $display("FAIL event: got %s v=%0d n=%0d, required %s v=%0d n=%0d",
                         kname(k), v, n, kname(e.kind), e.v, e.n);
            end
        end
    endfunction

    function automatic void check_int(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    function automatic void refresh();
        stk_empty  = (env_stk.size() == 0);
        stk_idx_in = stk_empty ? '0 : VB'(env_stk[$]);
    endfunction

    // Monitor + environment responder.
    always @(negedge clock) begin
        if ((stk_pop && stk_push) || (asg_rd_en && asg_wr_en)) overlaps++;
        if (reset) begin
            expq.delete();
            env_stk.delete();
            for (int i = 0; i < NV; i++) env_tab[i] = 2'b00;
            pop_pending = 1'b0;
            uw_cnt = 0;
            unwind_done = 1'b0;
            prev_unsat = 1'b0;
            prev_err = 1'b0;
            rd_prev = 1'b0;
            asg_rd_val = 2'b00;
        end else begin
            if (pop_pending && env_stk.size() > 0) void'(env_stk.pop_back());
            pop_pending = 1'b0;
            if (dec_new && dec_push) begin
                env_stk.push_back(int'(dec_new_var));
                env_tab[dec_new_var] = dec_val;
            end
            if (err && !prev_err) check_ev(EV_ERR, 0, 0);
            if (unsat && !prev_unsat) begin
                check_ev(EV_UNSAT, 0, 0);
                last_unsat_cyc = cyc;
            end
            prev_err = err;
            prev_unsat = unsat;
            if (stk_pop) begin
                check_ev(EV_POP, int'(stk_idx_in), 0);
                pop_pending = 1'b1;
            end
            if (unwind_req) begin
                if (uw_cnt == 0) uw_var = int'(unwind_var);
                unwind_done = (uw_cnt == uw_dly);
                uw_cnt++;
            end else begin
                if (uw_cnt != 0) check_ev(EV_UW, uw_var, uw_cnt);
                uw_cnt = 0;
                unwind_done = 1'b0;
            end
            if (asg_rd_en) begin
                check_ev(EV_RD, int'(asg_idx), 0);
                asg_rd_val = env_tab[asg_idx];
                rd_count++;
            end else if (!rd_prev) begin
                asg_rd_val = 2'($urandom);
            end
            rd_prev = asg_rd_en;
            if (asg_wr_en) begin
                check_ev(EV_WR, int'(asg_idx), int'(asg_wr_val));
                env_tab[asg_idx] = asg_wr_val;
            end
            if (stk_push) begin
                check_ev(EV_PUSH, int'(stk_idx_out), 0);
                env_stk.push_back(int'(stk_idx_out));
            end
            if (resume) begin
                check_ev(EV_RES, int'(resume_var), 0);
                last_res_cyc = cyc;
            end
        end
        refresh();
    end

    function automatic void expect_ev(int k, int v, int n);
        ev_t e;
        e.kind = k; e.v = v; e.n = n;
        expq.push_back(e);
    endfunction

    // Backtracking from the rules: pop until a never-flipped assigned
    // decision is found, flip it and push it back; otherwise unassign.
    function automatic void predict(int dly);
        int v;
        logic [1:0] val, nv;
        if (ref_unsat) return;
        if (ref_stk.size() == 0) begin
            expect_ev(EV_UNSAT, 0, 0);
            ref_unsat = 1'b1;
            return;
        end
        while (ref_stk.size() > 0) begin
            v = ref_stk.pop_back();
            val = ref_tab[v];
            expect_ev(EV_POP, v, 0);
            expect_ev(EV_UW, v, dly + 1);
            expect_ev(EV_RD, v, 0);
            if (!ref_flip[v] && val != 2'b00) begin
                nv = (val == 2'b01) ? 2'b10 : 2'b01;
                expect_ev(EV_WR, v, int'(nv));
                ref_tab[v] = nv;
                ref_flip[v] = 1'b1;
                ref_stk.push_back(v);
                expect_ev(EV_PUSH, v, 0);
                expect_ev(EV_RES, v, 0);
                return;
            end
            expect_ev(EV_WR, v, 0);
            ref_tab[v] = 2'b00;
            ref_flip[v] = 1'b0;
            if (val == 2'b00 && !ref_err) begin
                expect_ev(EV_ERR, 0, 0);
                ref_err = 1'b1;
            end
        end
        expect_ev(EV_UNSAT, 0, 0);
        ref_unsat = 1'b1;
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic decide(int v, logic [1:0] val);
        tick();
        dec_new = 1'b1; dec_new_var = VB'(v); dec_val = val; dec_push = 1'b1;
        ref_stk.push_back(v);
        ref_tab[v] = val;
        ref_flip[v] = 1'b0;
        tick();
        dec_new = 1'b0; dec_push = 1'b0;
    endtask

    task automatic fire(int dly);
        tick();
        uw_dly = dly; conflict = 1'b1; conf_cyc = cyc;
        predict(dly);
        tick();
        conflict = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            tick();
            n++;
        end while ((busy || expq.size() != 0) && n < 400);
        check_int("settle_pending", expq.size() + (busy ? 1000 : 0), 0);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1; conflict = 1'b0; dec_new = 1'b0; dec_push = 1'b0;
        ref_stk.delete();
        for (int i = 0; i < NV; i++) begin
            ref_tab[i] = 2'b00;
            ref_flip[i] = 1'b0;
        end
        ref_unsat = 1'b0; ref_err = 1'b0;
        tick();
        tick();
        check_int("reset_outputs",
                  int'({stk_pop, stk_push, stk_idx_out, unwind_req, unwind_var,
                        asg_rd_en, asg_idx, asg_wr_en, asg_wr_val, busy,
                        resume, resume_var, unsat, err}), 0);
        check_int("reset_bitmap", int'(dut.flipped), 0);
        reset = 1'b0;
    endtask

    task automatic check_model_state(string tag);
        for (int i = 0; i < NV; i++) begin
            check_int({tag, "_flipped"}, int'(dut.flipped[i]), int'(ref_flip[i]));
            check_int({tag, "_table"}, int'(env_tab[i]), int'(ref_tab[i]));
        end
        check_int({tag, "_unsat"}, int'(unsat), int'(ref_unsat));
        check_int({tag, "_err"}, int'(err), int'(ref_err));
    endtask

    task automatic random_phase();
        int v, nd;
        bit dup;
        logic [1:0] val;
        for (int it = 0; it < 40 && !ref_unsat; it++) begin
            nd = $urandom_range(0, 2);
            for (int k = 0; k < nd; k++) begin
                v = $urandom_range(0, NV - 1);
                dup = 1'b0;
                foreach (ref_stk[j]) if (ref_stk[j] == v) dup = 1'b1;
                if (!dup) begin
                    if ($urandom_range(0, 15) == 0) val = 2'b00;
                    else val = $urandom_range(0, 1) ? 2'b01 : 2'b10;
                    decide(v, val);
                end
            end
            fire($urandom_range(0, 3));
            wait_idle();
        end
    endtask

    initial begin
        int n, rd0;
        do_reset();

        // Stack [5,3], var3=10 unflipped: flip to 01, resume 3 at T+6.
        // A fresh-decision clear of var3 lands in the CHECK cycle; the set wins.
        decide(5, 2'b01);
        decide(3, 2'b10);
        rd0 = rd_count;
        fire(0);
        n = 0;
        while (rd_count == rd0 && n < 20) begin tick(); n++; end
        tick();
        dec_new = 1'b1; dec_new_var = 4'd3;
        tick();
        dec_new = 1'b0;
        wait_idle();
        check_int("resume_latency", last_res_cyc - conf_cyc, 6);

        // var3 flipped -> unassign, pop 5 (01) -> flip to 10, resume 5.
        fire(0);
        wait_idle();
        check_int("flipped3", int'(dut.flipped[3]), 0);
        check_int("flipped5", int'(dut.flipped[5]), 1);

        // Slow unwinder: request must be held for the whole wait.
        decide(7, 2'b10);
        fire(4);
        wait_idle();

        random_phase();
        check_model_state("random");

        // Reset in the middle of an unwind.
        do_reset();
        decide(6, 2'b01);
        fire(0);
        wait_idle();
        fire(50);
        n = 0;
        while (!unwind_req && n < 20) begin tick(); n++; end
        check_int("unwind_seen", int'(unwind_req), 1);
        tick(); tick();
        do_reset();

        // Stack [2], var2 flipped -> unassign, unsat; later conflict ignored.
        decide(2, 2'b10);
        fire(0);
        wait_idle();
        fire(0);
        wait_idle();
        check_int("unsat_sticky", int'(unsat), 1);
        fire(0);
        repeat (6) tick();
        check_int("unsat_hold", int'(unsat), 1);
        check_model_state("exhaust");

        // Conflict on an empty stack: unsat next cycle, no pop.
        do_reset();
        fire(0);
        wait_idle();
        check_int("unsat_latency", last_unsat_cyc - conf_cyc, 1);

        // Popped variable reads back unassigned.
        do_reset();
        decide(4, 2'b00);
        fire(1);
        wait_idle();
        check_model_state("errcase");

        check_int("overlap", overlaps, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
